// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle RV32 control FSM; CTRL_PERF_CNT_EN adds retired/cycle counters.
module multicycle_ctrl_fsm #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
`ifdef CTRL_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [4:0]  status,
  output logic        pcsrc,
  output logic        alusrc,
  output logic [3:0]  aluop,
  output logic        memrw,
  output logic        wb,
  output logic        regrw,
  output logic [1:0]  immgen_ctrl,
  output logic        pc_en,
  output logic        illegal
`ifdef CTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
`endif
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] IMM_NONE = 2'b00;
  localparam logic [1:0] IMM_I    = 2'b01;
  localparam logic [1:0] IMM_S    = 2'b10;
  localparam logic [1:0] IMM_B    = 2'b11;

  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  // S_NOP is the writeback-shaped retire cycle used for illegal opcodes when not trapping.
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_NOP
  } state_e;

  typedef enum logic [2:0] {
    K_ILL, K_R, K_I, K_LW, K_SW, K_BR
  } kind_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  kind_e       kind;
  logic [3:0]  dec_aluop;
  logic [1:0]  dec_imm;
  logic        dec_alusrc;
  logic        dec_wb;
  logic        taken;

  logic        status_z, status_n, status_c, status_o;
  logic        unused_bits;

  assign opcode   = ir_q[6:0];
  assign f3       = ir_q[14:12];
  assign f7       = ir_q[31:25];
  assign status_z = status[0];
  assign status_n = status[1];
  assign status_c = status[2];
  assign status_o = status[3];
  assign unused_bits = ^{status[4], ir_q[24:15], ir_q[11:7]};

  function automatic logic [3:0] base_aluop(input logic [2:0] fn3, input logic alt);
    logic [3:0] op;
    case (fn3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    kind      = K_ILL;
    dec_aluop = ALU_ADD;
    case (opcode)
      OP_R: begin
        if (f7 == 7'h00) begin
          kind      = K_R;
          dec_aluop = base_aluop(f3, 1'b0);
        end else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) begin
          kind      = K_R;
          dec_aluop = base_aluop(f3, 1'b1);
        end
      end
      OP_I: begin
        // Only the shift-immediates carry a funct7; every other I-ALU op uses those bits as immediate.
        if (f3 == 3'b001) begin
          if (f7 == 7'h00) kind = K_I;
        end else if (f3 == 3'b101) begin
          if (f7 == 7'h00 || f7 == 7'h20) kind = K_I;
        end else begin
          kind = K_I;
        end
        dec_aluop = base_aluop(f3, (f3 == 3'b101) && f7[5]);
      end
      OP_LW: if (f3 == 3'b010) kind = K_LW;
      OP_SW: if (f3 == 3'b010) kind = K_SW;
      OP_BR: begin
        if (f3 != 3'b010 && f3 != 3'b011) kind = K_BR;
        dec_aluop = ALU_SUB;
      end
      default: kind = K_ILL;
    endcase
  end

  always_comb begin
    dec_imm    = IMM_NONE;
    dec_alusrc = 1'b0;
    dec_wb     = 1'b0;
    case (kind)
      K_R:     dec_wb = 1'b1;
      K_I:     begin dec_imm = IMM_I; dec_alusrc = 1'b1; dec_wb = 1'b1; end
      K_LW:    begin dec_imm = IMM_I; dec_alusrc = 1'b1; end
      K_SW:    begin dec_imm = IMM_S; dec_alusrc = 1'b1; end
      K_BR:    dec_imm = IMM_B;
      default: dec_imm = IMM_NONE;
    endcase
  end

  // Branch resolution reads the live status bus in the EXEC cycle; c=1 means no borrow.
  always_comb begin
    case (f3)
      3'b000:  taken = status_z;
      3'b001:  taken = ~status_z;
      3'b100:  taken = status_n ^ status_o;
      3'b101:  taken = ~(status_n ^ status_o);
      3'b110:  taken = ~status_c;
      3'b111:  taken = status_c;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= IR_NOP;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (kind == K_ILL) state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_NOP;
        else               state_d = S_EXEC;
      end
      S_EXEC: begin
        case (kind)
          K_LW, K_SW: state_d = S_MEM;
          K_BR:       state_d = S_FETCH;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM:   state_d = (kind == K_SW) ? S_FETCH : S_WB;
      S_WB:    state_d = S_FETCH;
      S_NOP:   state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcsrc       = 1'b0;
    alusrc      = 1'b0;
    aluop       = ALU_ADD;
    memrw       = 1'b0;
    wb          = 1'b0;
    regrw       = 1'b0;
    immgen_ctrl = IMM_NONE;
    pc_en       = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_DECODE: immgen_ctrl = dec_imm;
      S_EXEC, S_MEM, S_WB: begin
        alusrc      = dec_alusrc;
        aluop       = dec_aluop;
        immgen_ctrl = dec_imm;
        wb          = dec_wb;
        if (state_q == S_EXEC && kind == K_BR) begin
          pcsrc = taken;
          pc_en = 1'b1;
        end
        if (state_q == S_MEM && kind == K_SW) begin
          memrw = 1'b1;
          pc_en = 1'b1;
        end
        if (state_q == S_WB) begin
          regrw = 1'b1;
          pc_en = 1'b1;
        end
      end
      S_NOP:   pc_en   = 1'b1;
      S_TRAP:  illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d  = cycles_q + CNT_W'(1);
    retired_d = retired_q + CNT_W'(pc_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q  <= '0;
      retired_q <= '0;
    end else begin
      cycles_q  <= cycles_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
  assign cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - bench for multicycle_ctrl_fsm (trap and non-trap builds side by side).
module tb_multicycle_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [4:0]  status;

  logic        pcsrc_a, alusrc_a, memrw_a, wb_a, regrw_a, pc_en_a, illegal_a;
  logic [3:0]  aluop_a;
  logic [1:0]  imm_a;
  logic        pcsrc_b, alusrc_b, memrw_b, wb_b, regrw_b, pc_en_b, illegal_b;
  logic [3:0]  aluop_b;
  logic [1:0]  imm_b;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_a, cycles_a, retired_b, cycles_b;
  int          exp_cycles;
`endif

  multicycle_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .status(status),
    .pcsrc(pcsrc_a), .alusrc(alusrc_a), .aluop(aluop_a), .memrw(memrw_a), .wb(wb_a),
    .regrw(regrw_a), .immgen_ctrl(imm_a), .pc_en(pc_en_a), .illegal(illegal_a)
`ifdef CTRL_PERF_CNT_EN
    , .retired(retired_a), .cycles(cycles_a)
`endif
  );

  multicycle_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut_nt (
    .clk(clk), .rst(rst), .instr(instr), .status(status),
    .pcsrc(pcsrc_b), .alusrc(alusrc_b), .aluop(aluop_b), .memrw(memrw_b), .wb(wb_b),
    .regrw(regrw_b), .immgen_ctrl(imm_b), .pc_en(pc_en_b), .illegal(illegal_b)
`ifdef CTRL_PERF_CNT_EN
    , .retired(retired_b), .cycles(cycles_b)
`endif
  );

  // Word layout: {pcsrc, alusrc, aluop[3:0], memrw, wb, regrw, immgen[1:0], pc_en, illegal}
  logic [12:0] word_a, word_b;
  assign word_a = {pcsrc_a, alusrc_a, aluop_a, memrw_a, wb_a, regrw_a, imm_a, pc_en_a, illegal_a};
  assign word_b = {pcsrc_b, alusrc_b, aluop_b, memrw_b, wb_b, regrw_b, imm_b, pc_en_b, illegal_b};

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  status;
    int          len;
    logic [3:0]  aluop;
    logic        alusrc;
    logic [1:0]  imm;
    logic        wb;
    logic        pcsrc;
    logic        memrw;
    logic        regrw;
    logic        legal;
  } vec_t;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7_any;
    logic [6:0] f7;
    logic [3:0] aluop;
  } op_t;

  op_t         ops[$];
  vec_t        vecs[$];
  int          total = 0;
  int          bad = 0;
  int          exp_retired = 0;
  logic [6:0]  opcs[5] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CTRL_PERF_CNT_EN
  always @(posedge clk or posedge rst) begin
    if (rst) exp_cycles <= 0;
    else     exp_cycles <= exp_cycles + 1;
  end
`endif

  function automatic op_t mkop(input logic [6:0] opc, input logic [2:0] f3, input logic f7_any,
                               input logic [6:0] f7, input logic [3:0] aluop);
    op_t o;
    o.opc = opc; o.f3 = f3; o.f7_any = f7_any; o.f7 = f7; o.aluop = aluop;
    return o;
  endfunction

  function automatic vec_t mkv(input logic [31:0] ins, input logic [4:0] st, input int len,
                               input logic [3:0] aluop, input logic alusrc, input logic [1:0] imm,
                               input logic wbv, input logic pcs, input logic mem, input logic reg_w,
                               input logic legal);
    vec_t v;
    v.instr = ins; v.status = st; v.len = len; v.aluop = aluop; v.alusrc = alusrc; v.imm = imm;
    v.wb = wbv; v.pcsrc = pcs; v.memrw = mem; v.regrw = reg_w; v.legal = legal;
    return v;
  endfunction

  // Reference: legality and ALU op come from a lookup over the instruction table,
  // timing and enables from the per-class cycle counts.
  function automatic vec_t model(input logic [31:0] ins, input logic [4:0] st);
    vec_t e;
    logic z, n, c, o;
    e = mkv(ins, st, 3, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (ops[i]) begin
      if (ops[i].opc == ins[6:0] && ops[i].f3 == ins[14:12] &&
          (ops[i].f7_any || ops[i].f7 == ins[31:25])) begin
        e.legal = 1'b1;
        e.aluop = ops[i].aluop;
      end
    end
    if (!e.legal) return e;
    {o, c, n, z} = st[3:0];
    case (ins[6:0])
      7'h33: begin e.len = 4; e.wb = 1; e.regrw = 1; end
      7'h13: begin e.len = 4; e.alusrc = 1; e.imm = 2'b01; e.wb = 1; e.regrw = 1; end
      7'h03: begin e.len = 5; e.alusrc = 1; e.imm = 2'b01; e.regrw = 1; end
      7'h23: begin e.len = 4; e.alusrc = 1; e.imm = 2'b10; e.memrw = 1; end
      default: begin
        e.len = 3; e.imm = 2'b11;
        case (ins[14:12])
          3'd0: e.pcsrc = z;
          3'd1: e.pcsrc = !z;
          3'd4: e.pcsrc = n != o;
          3'd5: e.pcsrc = n == o;
          3'd6: e.pcsrc = !c;
          default: e.pcsrc = c;
        endcase
      end
    endcase
    return e;
  endfunction

  function automatic logic [12:0] exp_word(input vec_t e, input int c, input logic trap);
    logic [12:0] w;
    w = '0;
    if (!e.legal) begin
      if (c >= 3) w = trap ? 13'b1 : ((c == 3) ? 13'b10 : 13'b0);
      return w;
    end
    if (c == 2) w[3:2] = e.imm;
    if (c >= 3) begin
      w[11]   = e.alusrc;
      w[10:7] = e.aluop;
      w[5]    = e.wb;
      w[3:2]  = e.imm;
      if (c == 3) w[12] = e.pcsrc;
      if (c == e.len) begin
        w[1] = 1'b1;
        w[6] = e.memrw;
        w[4] = e.regrw;
      end
    end
    return w;
  endfunction

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d instr=%08h actual=%h required=%h", name, cyc, instr, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dut"}, 0, 32'(word_a), 32'd0);
    check({tag, "_dut_nt"}, 0, 32'(word_b), 32'd0);
`ifdef CTRL_PERF_CNT_EN
    check({tag, "_retired"}, 0, retired_a, 32'd0);
    check({tag, "_cycles"}, 0, cycles_a, 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_retired = 0;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_instr(input vec_t e, input int abort_at);
    for (int c = 1; c <= e.len; c++) begin
      @(negedge clk);
      if (c == 1) instr = e.instr;
      status = (c == 3) ? e.status : 5'($urandom);
      #1;
      check("ctrl_trap", c, 32'(word_a), 32'(exp_word(e, c, 1'b1)));
      check("ctrl_notrap", c, 32'(word_b), 32'(exp_word(e, c, 1'b0)));
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        exp_retired = 0;
        check_all_zero("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
`ifdef CTRL_PERF_CNT_EN
      if (c == e.len) begin
        check("retired", c, retired_a, 32'(exp_retired));
        check("cycles", c, cycles_a, 32'(exp_cycles));
      end
`endif
    end
    if (e.legal) exp_retired++;
    else         do_reset();
  endtask

  initial begin
    rst    = 1'b1;
    instr  = 32'h0000_0013;
    status = 5'b0;

    ops.push_back(mkop(7'h33, 3'd0, 0, 7'h00, 4'd0));
    ops.push_back(mkop(7'h33, 3'd0, 0, 7'h20, 4'd1));
    ops.push_back(mkop(7'h33, 3'd1, 0, 7'h00, 4'd5));
    ops.push_back(mkop(7'h33, 3'd2, 0, 7'h00, 4'd8));
    ops.push_back(mkop(7'h33, 3'd3, 0, 7'h00, 4'd9));
    ops.push_back(mkop(7'h33, 3'd4, 0, 7'h00, 4'd4));
    ops.push_back(mkop(7'h33, 3'd5, 0, 7'h00, 4'd6));
    ops.push_back(mkop(7'h33, 3'd5, 0, 7'h20, 4'd7));
    ops.push_back(mkop(7'h33, 3'd6, 0, 7'h00, 4'd3));
    ops.push_back(mkop(7'h33, 3'd7, 0, 7'h00, 4'd2));
    ops.push_back(mkop(7'h13, 3'd0, 1, 7'h00, 4'd0));
    ops.push_back(mkop(7'h13, 3'd2, 1, 7'h00, 4'd8));
    ops.push_back(mkop(7'h13, 3'd3, 1, 7'h00, 4'd9));
    ops.push_back(mkop(7'h13, 3'd4, 1, 7'h00, 4'd4));
    ops.push_back(mkop(7'h13, 3'd6, 1, 7'h00, 4'd3));
    ops.push_back(mkop(7'h13, 3'd7, 1, 7'h00, 4'd2));
    ops.push_back(mkop(7'h13, 3'd1, 0, 7'h00, 4'd5));
    ops.push_back(mkop(7'h13, 3'd5, 0, 7'h00, 4'd6));
    ops.push_back(mkop(7'h13, 3'd5, 0, 7'h20, 4'd7));
    ops.push_back(mkop(7'h03, 3'd2, 1, 7'h00, 4'd0));
    ops.push_back(mkop(7'h23, 3'd2, 1, 7'h00, 4'd0));
    foreach (opcs[i]) if (i == 4) begin
      ops.push_back(mkop(7'h63, 3'd0, 1, 7'h00, 4'd1));
      ops.push_back(mkop(7'h63, 3'd1, 1, 7'h00, 4'd1));
      ops.push_back(mkop(7'h63, 3'd4, 1, 7'h00, 4'd1));
      ops.push_back(mkop(7'h63, 3'd5, 1, 7'h00, 4'd1));
      ops.push_back(mkop(7'h63, 3'd6, 1, 7'h00, 4'd1));
      ops.push_back(mkop(7'h63, 3'd7, 1, 7'h00, 4'd1));
    end

    //                 instr          status    len aluop alusrc imm   wb pcs mem reg legal
    vecs.push_back(mkv(32'h002081B3, 5'b00000, 4, 4'd0, 0, 2'b00, 1, 0, 0, 1, 1)); // ADD
    vecs.push_back(mkv(32'h0080A283, 5'b00000, 5, 4'd0, 1, 2'b01, 0, 0, 0, 1, 1)); // LW
    vecs.push_back(mkv(32'h0050A623, 5'b00000, 4, 4'd0, 1, 2'b10, 0, 0, 1, 0, 1)); // SW
    vecs.push_back(mkv(32'h00208463, 5'b00001, 3, 4'd1, 0, 2'b11, 0, 1, 0, 0, 1)); // BEQ taken
    vecs.push_back(mkv(32'h00208463, 5'b00000, 3, 4'd1, 0, 2'b11, 0, 0, 0, 0, 1)); // BEQ not taken
    vecs.push_back(mkv(32'h402081B3, 5'b00000, 4, 4'd1, 0, 2'b00, 1, 0, 0, 1, 1)); // SUB
    vecs.push_back(mkv(32'h4030D093, 5'b00000, 4, 4'd7, 1, 2'b01, 1, 0, 0, 1, 1)); // SRAI
    vecs.push_back(mkv(32'h0020E463, 5'b00000, 3, 4'd1, 0, 2'b11, 0, 1, 0, 0, 1)); // BLTU borrow
    vecs.push_back(mkv(32'h0020D463, 5'b01010, 3, 4'd1, 0, 2'b11, 0, 1, 0, 0, 1)); // BGE n=o=1
    vecs.push_back(mkv(32'h0020C463, 5'b00010, 3, 4'd1, 0, 2'b11, 0, 1, 0, 0, 1)); // BLT n^o
    vecs.push_back(mkv(32'h0050B093, 5'b00000, 4, 4'd9, 1, 2'b01, 1, 0, 0, 1, 1)); // SLTIU
    vecs.push_back(mkv(32'h40109093, 5'b00000, 3, 4'd0, 0, 2'b00, 0, 0, 0, 0, 0)); // SLLI bad f7
    vecs.push_back(mkv(32'h00000000, 5'b00000, 3, 4'd0, 0, 2'b00, 0, 0, 0, 0, 0)); // all zero

    #2;
    check_all_zero("power_on");
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) run_instr(vecs[i], 0);

    // Trap hold: illegal stays up with no enables for 20 cycles, only rst leaves.
    do_reset();
    begin
      vec_t e;
      e = vecs[12];
      for (int c = 1; c <= 22; c++) begin
        @(negedge clk);
        if (c == 1) instr = e.instr;
        status = 5'($urandom);
        #1;
        check("trap_hold", c, 32'(word_a), 32'(exp_word(e, c, 1'b1)));
        if (c == 3) check("nop_retire", c, 32'(word_b), 32'(exp_word(e, c, 1'b0)));
      end
    end
    do_reset();

    // Reset in the EXEC cycle of a load, then a clean instruction afterwards.
    run_instr(vecs[1], 3);
    run_instr(vecs[0], 0);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        r[6:0] = opcs[$urandom_range(0, 4)];
        case ($urandom_range(0, 2))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          default: ;
        endcase
        if ((r[6:0] == 7'h03 || r[6:0] == 7'h23) && $urandom_range(0, 3) != 0) r[14:12] = 3'b010;
      end
      run_instr(model(r, 5'($urandom)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
